// File: rtl/debug_pkg.sv
// Shared constants and types for the debug step/dump controller.
// Command bytes, frame delimiters, FSM state and frame-section encodings.
package debug_pkg;

  localparam logic [7:0] CMD_RUN   = 8'h63;
  localparam logic [7:0] CMD_PAUSE = 8'h70;
  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_DUMP  = 8'h64;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam logic [7:0] FRAME_TRL = 8'h5A;

  typedef enum logic [2:0] {
    ST_PAUSED,
    ST_RUN,
    ST_STEP,
    ST_HALTED,
    ST_DUMP
  } ctrl_state_e;

  typedef enum logic [2:0] {
    SEC_IDLE,
    SEC_HDR,
    SEC_REG,
    SEC_STS,
    SEC_TRL
  } frame_sec_e;

  // Counter width for n distinct values; a single-value counter still gets one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debug_frame_serializer.sv
// Byte sequencer for one dump frame: header, register words, control status, trailer.
// Started by a one-cycle start pulse; emits a one-cycle done pulse after the trailer handshake.
module debug_frame_serializer
  import debug_pkg::*;
#(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int SELW = 5,
  parameter int CW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            done,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic [SELW-1:0] dbg_sel,
  input  logic [DW-1:0]   dbg_data,
  input  logic [CW-1:0]   ctrl_status,
  output logic            dumping
);

  localparam int WB = DW / 8;
  localparam int CB = CW / 8;
  localparam int IW = cnt_w(NREG);
  localparam int BW = cnt_w(WB);
  localparam int SW = cnt_w(CB);

  frame_sec_e      sec;
  logic [IW-1:0]   reg_idx;
  logic [BW-1:0]   byte_idx;
  logic [SW-1:0]   sts_idx;
  logic            xfer;

  assign xfer    = tx_valid && tx_ready;
  // reg_idx is parked at 0 outside the register section, so it doubles as dbg_sel.
  assign dbg_sel = SELW'(reg_idx);
  assign dumping = tx_valid;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      sec      <= SEC_IDLE;
      reg_idx  <= '0;
      byte_idx <= '0;
      sts_idx  <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (sec)
        SEC_IDLE: if (start) begin
          sec      <= SEC_HDR;
          tx_valid <= 1'b1;
        end
        SEC_HDR: if (xfer) sec <= SEC_REG;
        SEC_REG: if (xfer) begin
          if (byte_idx == BW'(WB - 1)) begin
            byte_idx <= '0;
            if (reg_idx == IW'(NREG - 1)) begin
              reg_idx <= '0;
              sec     <= SEC_STS;
            end else begin
              reg_idx <= reg_idx + 1'b1;
            end
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
        SEC_STS: if (xfer) begin
          if (sts_idx == SW'(CB - 1)) begin
            sts_idx <= '0;
            sec     <= SEC_TRL;
          end else begin
            sts_idx <= sts_idx + 1'b1;
          end
        end
        SEC_TRL: if (xfer) begin
          sec      <= SEC_IDLE;
          tx_valid <= 1'b0;
          done     <= 1'b1;
        end
        default: sec <= SEC_IDLE;
      endcase
    end
  end

  // NOTE: tx_data gets a default before the case so no path leaves it unassigned,
  // which keeps this a pure mux instead of an inferred latch.
  always_comb begin
    tx_data = 8'h00;
    case (sec)
      SEC_HDR: tx_data = FRAME_HDR;
      SEC_REG: tx_data = 8'(dbg_data >> {byte_idx, 3'b000});
      SEC_STS: tx_data = 8'(ctrl_status >> {sts_idx, 3'b000});
      SEC_TRL: tx_data = FRAME_TRL;
      default: tx_data = 8'h00;
    endcase
  end

endmodule

// File: rtl/debug_step_dump_ctrl.sv
// UART debug controller for the pipelined core: run/pause/step command FSM,
// halt-instruction detection, and framed register/status dump via the serializer.
module debug_step_dump_ctrl
  import debug_pkg::*;
#(
  parameter int          DW         = 32,
  parameter int          NREG       = 32,
  parameter int          SELW       = 5,
  parameter int          CW         = 16,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter bit          AUTO_DUMP  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic [SELW-1:0] dbg_sel,
  input  logic [DW-1:0]   dbg_data,
  input  logic [31:0]     instr_latch,
  input  logic [CW-1:0]   ctrl_status,
  output logic            pipe_enable,
  output logic            halted,
  output logic            dumping,
  output logic            cmd_drop
);

  ctrl_state_e state;
  logic        frame_start;
  logic        frame_done;
  logic        halt_hit;

  // Only RUN and STEP enable the pipeline, so this can only fire in those states.
  assign halt_hit = pipe_enable && (instr_latch == HALT_INSTR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_PAUSED;
      pipe_enable <= 1'b0;
      halted      <= 1'b0;
      cmd_drop    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cmd_drop    <= 1'b0;
      frame_start <= 1'b0;
      if (halt_hit) begin
        // Halt wins over any command byte arriving in the same cycle.
        pipe_enable <= 1'b0;
        halted      <= 1'b1;
        state       <= AUTO_DUMP ? ST_DUMP : ST_HALTED;
        frame_start <= AUTO_DUMP;
      end else begin
        case (state)
          ST_PAUSED: if (rx_valid) begin
            case (rx_data)
              CMD_RUN: begin
                state       <= ST_RUN;
                pipe_enable <= 1'b1;
              end
              CMD_STEP: begin
                state       <= ST_STEP;
                pipe_enable <= 1'b1;
              end
              CMD_DUMP: begin
                state       <= ST_DUMP;
                frame_start <= 1'b1;
              end
              default: ;
            endcase
          end
          ST_RUN: if (rx_valid && rx_data == CMD_PAUSE) begin
            state       <= ST_PAUSED;
            pipe_enable <= 1'b0;
          end
          ST_STEP: begin
            pipe_enable <= 1'b0;
            if (AUTO_DUMP) begin
              state       <= ST_DUMP;
              frame_start <= 1'b1;
            end else begin
              state <= ST_PAUSED;
            end
          end
          ST_HALTED: if (rx_valid) begin
            if (rx_data == CMD_DUMP) begin
              state       <= ST_DUMP;
              frame_start <= 1'b1;
            end else if (rx_data == CMD_RUN || rx_data == CMD_STEP) begin
              cmd_drop <= 1'b1;
            end
          end
          ST_DUMP: begin
            if (rx_valid) cmd_drop <= 1'b1;
            if (frame_done) state <= halted ? ST_HALTED : ST_PAUSED;
          end
          default: state <= ST_PAUSED;
        endcase
      end
    end
  end

  debug_frame_serializer #(
    .DW   (DW),
    .NREG (NREG),
    .SELW (SELW),
    .CW   (CW)
  ) u_serializer (
    .clk         (clk),
    .reset       (reset),
    .start       (frame_start),
    .done        (frame_done),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data),
    .ctrl_status (ctrl_status),
    .dumping     (dumping)
  );

endmodule

// File: tb/tb_debug_step_dump_ctrl.sv
// Directed/randomized bench for debug_step_dump_ctrl: default build plus a small
// NREG=8/DW=16/CW=8 build, with frames compared against a byte-list model.
module tb_debug_step_dump_ctrl;
  import debug_pkg::*;

  localparam int NREG = 32, DW = 32, CW = 16, WB = 4, CB = 2;
  localparam int S_NREG = 8, S_DW = 16, S_CW = 8, S_WB = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // default-parameter instance
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [4:0]  dbg_sel;
  logic [31:0] dbg_data;
  logic [31:0] instr_latch = 32'h0;
  logic [15:0] ctrl_status = 16'h0;
  logic        pipe_enable, halted, dumping, cmd_drop;
  logic [31:0] regs [NREG];

  assign dbg_data = regs[dbg_sel];

  debug_step_dump_ctrl dut (
    .clk (clk), .reset (reset), .rx_data (rx_data), .rx_valid (rx_valid),
    .tx_data (tx_data), .tx_valid (tx_valid), .tx_ready (tx_ready),
    .dbg_sel (dbg_sel), .dbg_data (dbg_data), .instr_latch (instr_latch),
    .ctrl_status (ctrl_status), .pipe_enable (pipe_enable), .halted (halted),
    .dumping (dumping), .cmd_drop (cmd_drop)
  );

  // small instance
  logic [7:0]  s_rx_data = 8'h00;
  logic        s_rx_valid = 1'b0;
  logic        s_tx_ready = 1'b1;
  logic [7:0]  s_tx_data;
  logic        s_tx_valid;
  logic [2:0]  s_dbg_sel;
  logic [15:0] s_dbg_data;
  logic [7:0]  s_ctrl_status = 8'h0;
  logic        s_pipe_enable, s_halted, s_dumping, s_cmd_drop;
  logic [15:0] s_regs [S_NREG];

  assign s_dbg_data = s_regs[s_dbg_sel];

  debug_step_dump_ctrl #(.DW(S_DW), .NREG(S_NREG), .SELW(3), .CW(S_CW)) dut_s (
    .clk (clk), .reset (reset), .rx_data (s_rx_data), .rx_valid (s_rx_valid),
    .tx_data (s_tx_data), .tx_valid (s_tx_valid), .tx_ready (s_tx_ready),
    .dbg_sel (s_dbg_sel), .dbg_data (s_dbg_data), .instr_latch (32'h0),
    .ctrl_status (s_ctrl_status), .pipe_enable (s_pipe_enable), .halted (s_halted),
    .dumping (s_dumping), .cmd_drop (s_cmd_drop)
  );

  int n_checks = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] v;
    v = $urandom;
    if (v == 32'hFFFF_FFFF) v = 32'h0;
    return v;
  endfunction

  task automatic rand_model();
    for (int r = 0; r < NREG; r++) regs[r] = $urandom;
    ctrl_status = 16'($urandom);
  endtask

  // Expected frame as a flat byte list: header, words LSB first, status LSB first, trailer.
  function automatic void build_exp();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int r = 0; r < NREG; r++)
      for (int b = 0; b < WB; b++) exp_q.push_back(regs[r][8*b +: 8]);
    for (int b = 0; b < CB; b++) exp_q.push_back(ctrl_status[8*b +: 8]);
    exp_q.push_back(8'h5A);
  endfunction

  function automatic int exp_sel(input int k, input int nreg, input int wb);
    return (k >= 1 && k <= nreg * wb) ? (k - 1) / wb : 0;
  endfunction

  task automatic collect_frame(input bit rand_ready, input string tag);
    int cyc;
    logic [7:0] prev;
    bit stalled;
    build_exp();
    got.delete();
    cyc = 0;
    stalled = 1'b0;
    prev = 8'h00;
    while (!tx_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check({tag, "_valid_rise"}, 32'(tx_valid), 1);
    cyc = 0;
    while (tx_valid && got.size() < exp_q.size() && cyc < 4000) begin
      if (stalled) check($sformatf("%s_stall_hold%0d", tag, got.size()), 32'(tx_data), 32'(prev));
      tx_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (tx_ready) begin
        check($sformatf("%s_byte%0d", tag, got.size()), 32'(tx_data), 32'(exp_q[got.size()]));
        check($sformatf("%s_sel%0d", tag, got.size()), 32'(dbg_sel), exp_sel(got.size(), NREG, WB));
        check($sformatf("%s_dumping%0d", tag, got.size()), 32'(dumping), 1);
        got.push_back(tx_data);
      end
      stalled = !tx_ready;
      prev = tx_data;
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    check({tag, "_length"}, got.size(), exp_q.size());
    if (!rand_ready) check({tag, "_no_bubbles"}, cyc, exp_q.size());
    check({tag, "_valid_fall"}, 32'(tx_valid), 0);
    check({tag, "_dumping_fall"}, 32'(dumping), 0);
    check({tag, "_pe_low"}, 32'(pipe_enable), 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, cyc;
    logic [7:0] s_exp[$];

    for (int r = 0; r < NREG; r++) regs[r] = 32'h0;
    for (int r = 0; r < S_NREG; r++) s_regs[r] = 16'h0;

    // reset values
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_pipe_enable", 32'(pipe_enable), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_dbg_sel", 32'(dbg_sel), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_dumping", 32'(dumping), 0);
    check("rst_cmd_drop", 32'(cmd_drop), 0);

    // single step: one enable cycle, then auto-dump
    rand_model();
    instr_latch = rand_instr();
    send(CMD_STEP);
    check("step_pe_on", 32'(pipe_enable), 1);
    tick();
    check("step_pe_off", 32'(pipe_enable), 0);
    check("step_valid_not_yet", 32'(tx_valid), 0);
    tick();
    check("step_valid_now", 32'(tx_valid), 1);
    collect_frame(1'b0, "step");
    check("step_not_halted", 32'(halted), 0);

    // run, ignored commands, pause
    send(CMD_RUN);
    check("run_pe_on", 32'(pipe_enable), 1);
    for (int i = 0; i < 3; i++) begin
      instr_latch = rand_instr();
      tick();
    end
    send(CMD_DUMP);
    send(CMD_STEP);
    check("run_ignore_pe", 32'(pipe_enable), 1);
    check("run_ignore_tx", 32'(tx_valid), 0);
    check("run_ignore_drop", 32'(cmd_drop), 0);
    send(CMD_PAUSE);
    check("pause_pe_off", 32'(pipe_enable), 0);
    tick();
    check("pause_pe_stays", 32'(pipe_enable), 0);

    // halt detection beats a simultaneous pause
    rand_model();
    send(CMD_RUN);
    check("run2_pe_on", 32'(pipe_enable), 1);
    tick();
    tick();
    instr_latch = 32'hFFFF_FFFF;
    rx_data = CMD_PAUSE;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    instr_latch = rand_instr();
    check("halt_pe_off", 32'(pipe_enable), 0);
    check("halt_flag", 32'(halted), 1);
    collect_frame(1'b1, "halt");
    check("halt_sticky", 32'(halted), 1);
    send(CMD_RUN);
    check("halted_c_drop", 32'(cmd_drop), 1);
    check("halted_c_pe", 32'(pipe_enable), 0);
    tick();
    check("halted_drop_pulse", 32'(cmd_drop), 0);

    // explicit dump from HALTED with a known register value
    rand_model();
    regs[5] = 32'h1234_5678;
    send(CMD_DUMP);
    collect_frame(1'b1, "hdump");
    check("reg5_b0", 32'(got[21]), 32'h78);
    check("reg5_b1", 32'(got[22]), 32'h56);
    check("reg5_b2", 32'(got[23]), 32'h34);
    check("reg5_b3", 32'(got[24]), 32'h12);
    send(CMD_STEP);
    check("back_to_halted", 32'(cmd_drop), 1);
    check("still_halted", 32'(halted), 1);

    // reset clears halt; dump from PAUSED with a mid-frame command and reset abort
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_halted", 32'(halted), 0);
    rand_model();
    send(CMD_DUMP);
    cyc = 0;
    while (!tx_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check("abort_valid_rise", 32'(tx_valid), 1);
    build_exp();
    n = 0;
    cyc = 0;
    while (n < 40 && tx_valid && cyc < 200) begin
      check($sformatf("abort_byte%0d", n), 32'(tx_data), 32'(exp_q[n]));
      n++;
      if (n == 10) begin
        rx_data = CMD_STEP;
        rx_valid = 1'b1;
      end
      tick();
      cyc++;
      if (n == 10) begin
        rx_valid = 1'b0;
        check("dump_cmd_drop", 32'(cmd_drop), 1);
      end
    end
    check("abort_reached_40", n, 40);
    reset = 1'b1;
    tick();
    check("abort_tx_valid", 32'(tx_valid), 0);
    check("abort_tx_data", 32'(tx_data), 0);
    check("abort_dbg_sel", 32'(dbg_sel), 0);
    check("abort_dumping", 32'(dumping), 0);
    check("abort_pe", 32'(pipe_enable), 0);
    check("abort_halted", 32'(halted), 0);
    check("abort_cmd_drop", 32'(cmd_drop), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("abort_no_resume", 32'(tx_valid), 0);

    // small configuration: 8 x 16-bit registers, 8-bit status -> 19 bytes
    for (int r = 0; r < S_NREG; r++) s_regs[r] = 16'($urandom);
    s_ctrl_status = 8'($urandom);
    s_exp.push_back(8'hA5);
    for (int r = 0; r < S_NREG; r++)
      for (int b = 0; b < S_WB; b++) s_exp.push_back(s_regs[r][8*b +: 8]);
    s_exp.push_back(s_ctrl_status);
    s_exp.push_back(8'h5A);
    s_rx_data = CMD_DUMP;
    s_rx_valid = 1'b1;
    tick();
    s_rx_valid = 1'b0;
    cyc = 0;
    while (!s_tx_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check("small_valid_rise", 32'(s_tx_valid), 1);
    n = 0;
    cyc = 0;
    while (s_tx_valid && n < 40 && cyc < 100) begin
      if (n < s_exp.size())
        check($sformatf("small_byte%0d", n), 32'(s_tx_data), 32'(s_exp[n]));
      check($sformatf("small_sel%0d", n), 32'(s_dbg_sel), exp_sel(n, S_NREG, S_WB));
      n++;
      tick();
      cyc++;
    end
    check("small_length", n, 19);
    check("small_valid_fall", 32'(s_tx_valid), 0);
    check("small_dumping_fall", 32'(s_dumping), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/debug_step_dump_ctrl.md
Name: debug_step_dump_ctrl

Overview:
Parametrised successor to the UART debug unit for the pipelined MIPS core. It decodes single-byte UART commands to run, pause or single-step the pipeline. It detects the halt instruction and serialises a framed snapshot of the register file and pipeline control status into a byte stream for the UART transmitter. The register file is read through a select/data port instead of flat per-register inputs, so register count and width are parameters.

Parameters:
DW, 32, register word width in bits; must be a multiple of 8
NREG, 32, number of registers dumped; must be at least 1
SELW, 5, width of dbg_sel; must satisfy 2^SELW >= NREG
CW, 16, width of ctrl_status in bits; must be a multiple of 8
HALT_INSTR, 32'hFFFF_FFFF, instruction encoding that halts the pipeline
AUTO_DUMP, 1, 1 = dump automatically after each step and on halt

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rx_data  in  8  received command byte
rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle
tx_data  out  8  byte offered to the UART transmitter
tx_valid  out  1  tx_data is valid
tx_ready  in  1  transmitter accepts the byte; transfer happens when tx_valid && tx_ready
dbg_sel  out  SELW  register-file read index
dbg_data  in  DW  combinational register-file read data for dbg_sel
instr_latch  in  32  instruction currently in the decode latch
ctrl_status  in  CW  packed ID/EX/MEM control bits
pipe_enable  out  1  pipeline clock enable
halted  out  1  sticky halt flag
dumping  out  1  a frame is in progress
cmd_drop  out  1  one-cycle pulse when a received byte is discarded

Behaviour:
- Interface rule: one clock (clk); reset is synchronous and active-high.
- Reset values: pipe_enable=0, tx_valid=0, tx_data=0, dbg_sel=0, halted=0, dumping=0, cmd_drop=0. State=PAUSED.
- States: PAUSED, RUN, STEP, HALTED, DUMP. Every output is registered except tx_data, which is a combinational mux.
- Command codes: 0x63 'c' = run, 0x70 'p' = pause, 0x73 's' = step, 0x64 'd' = dump. Any other byte is ignored silently.
- PAUSED:
  - 'c' -> RUN; pipe_enable=1 from the next cycle.
  - 's' -> STEP; pipe_enable=1 for exactly one cycle (the cycle after the rx_valid strobe), then back to PAUSED, or to DUMP if AUTO_DUMP=1.
  - 'd' -> DUMP.
- RUN:
  - 'p' -> PAUSED; pipe_enable=0 the next cycle.
  - 'c', 's', 'd' are ignored.
- Halt detection:
  - Condition: pipe_enable==1 and instr_latch==HALT_INSTR in cycle n.
  - Cycle n+1: pipe_enable=0 and halted=1. State becomes HALTED, or DUMP if AUTO_DUMP=1.
  - Halt takes priority over a simultaneous 'p' or 's' byte.
- HALTED: only 'd' is accepted; 'c' and 's' set cmd_drop. halted clears only on reset.
- DUMP:
  - pipe_enable is held 0 for the whole frame, so dbg_data and ctrl_status stay stable.
  - Frame order: header 0xA5; then registers 0..NREG-1, each DW/8 bytes, LSB first; then ctrl_status as CW/8 bytes, LSB first; then trailer 0x5A.
  - Frame length = 2 + NREG*DW/8 + CW/8 bytes (132 at defaults).
  - tx_valid rises the cycle after DUMP is entered. dumping=1 from that cycle until the cycle after the trailer handshake.
  - tx_data is stable while tx_valid && !tx_ready. Each handshake advances exactly one byte. No bubble is required between bytes: tx_valid stays high across back-to-back handshakes.
  - dbg_sel equals the index of the register being sent. It is 0 outside the register section.
  - After the trailer, return to HALTED if halted=1, else PAUSED.
- Any rx_valid during DUMP is discarded, with a cmd_drop pulse in the same cycle+1.
- Reset mid-frame aborts the frame: tx_valid=0 on the next cycle and no trailer is sent.
- Byte and word counters are sized with $clog2. They never wrap within a frame; the register-index counter terminates at NREG-1.

Decomposition:
- Package debug_pkg: command byte constants, FRAME_HDR/FRAME_TRL constants, and the state enum.
- Sub-module debug_frame_serializer: contains the header/register/status/trailer byte sequencer and the tx handshake. It is started by a one-cycle start pulse and returns a done pulse.
- The top level holds the command FSM and halt detection.

Test Plan:
- Reset, then 's' with tx_ready=1 and AUTO_DUMP=1 -> pipe_enable high for exactly 1 cycle. Then 132 bytes: 0xA5, reg0 LSB first, ..., 0x5A. Final state PAUSED.
- 'c', then drive instr_latch=32'hFFFF_FFFF at cycle n -> pipe_enable=0 and halted=1 at n+1. The auto-dump frame follows. A later 'c' gives a cmd_drop pulse and pipe_enable stays 0.
- 'd' while PAUSED, with tx_ready toggling randomly -> tx_data is stable whenever stalled. The byte stream matches the reference model (e.g. reg5=32'h1234_5678 -> bytes 78 56 34 12).
- 'c' then 'p' -> pipe_enable is high between the strobes and low one cycle after 'p'. The 'd' sent in between is ignored.
- Send 's' mid-dump -> cmd_drop pulse, frame unaffected. Then assert reset at byte 40 -> tx_valid=0 next cycle, and all outputs return to their reset values.
- Rerun with NREG=8, DW=16, CW=8 -> frame is 19 bytes and dbg_sel sequences 0..7.
